// File: rtl/tour_move_sched_pkg.sv
// Shared constants, state enum and command-building helper for the knight-tour move scheduler.
// Build option: TOUR_FANFARE_EN selects the fanfare opcode for horizontal legs.
package tour_move_sched_pkg;

  localparam logic [3:0] OPC_MOVE    = 4'h4;
  localparam logic [3:0] OPC_FANFARE = 4'h5;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_INT = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    V_LEG,
    V_WAIT,
    H_LEG,
    H_WAIT
  } tour_state_e;

  // Builds {opcode, heading, squares}; heading picked by the sign of the signed offset d.
  function automatic logic [15:0] leg_cmd(input logic [3:0] opc,
                                          input logic [2:0] d,
                                          input logic [7:0] hdg_pos,
                                          input logic [7:0] hdg_neg);
    logic [2:0] mag;
    logic       pos;
    mag = d[2] ? (3'd0 - d) : d;
    pos = !d[2] && (d != 3'd0);
    return {opc, (pos ? hdg_pos : hdg_neg), {1'b0, mag}};
  endfunction

endpackage

// File: rtl/tour_move_sched_knight_move_decode.sv
// Combinational decode of a one-hot knight move into signed (dx, dy) plus a valid flag.
// Zero or multi-hot encodings give valid = 0 and zero offsets.
module knight_move_decode (
  input  logic              [7:0] move,
  output logic signed       [2:0] dx,
  output logic signed       [2:0] dy,
  output logic                    valid
);

  always_comb begin
    dx    = '0;
    dy    = '0;
    valid = 1'b0;
    case (move)
      8'h01: begin dx =  3'sd1; dy =  3'sd2; valid = 1'b1; end
      8'h02: begin dx = -3'sd1; dy =  3'sd2; valid = 1'b1; end
      8'h04: begin dx = -3'sd2; dy =  3'sd1; valid = 1'b1; end
      8'h08: begin dx = -3'sd2; dy = -3'sd1; valid = 1'b1; end
      8'h10: begin dx = -3'sd1; dy = -3'sd2; valid = 1'b1; end
      8'h20: begin dx =  3'sd1; dy = -3'sd2; valid = 1'b1; end
      8'h40: begin dx =  3'sd2; dy = -3'sd1; valid = 1'b1; end
      8'h80: begin dx =  3'sd2; dy =  3'sd1; valid = 1'b1; end
      default: begin
        dx    = '0;
        dy    = '0;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/tour_move_sched.sv
// Sequences a solved knight tour into vertical/horizontal move commands for cmd_proc,
// and passes UART commands straight through while idle. Option: TOUR_FANFARE_EN.
//
// state  | meaning
// IDLE   | UART passthrough, waiting for start_tour
// V_LEG  | decode move, then hold vertical command until clr_cmd_rdy
// V_WAIT | vertical leg executing, waiting for send_resp
// H_LEG  | hold horizontal command until clr_cmd_rdy
// H_WAIT | horizontal leg executing; send_resp advances or ends the tour
module tour_move_sched
  import tour_move_sched_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [7:0]  resp,
  output logic        tour_err
);

`ifdef TOUR_FANFARE_EN
  localparam logic [3:0] OPC_H = OPC_FANFARE;
`else
  localparam logic [3:0] OPC_H = OPC_MOVE;
`endif

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  tour_state_e       state_q, state_d;
  logic [4:0]        mv_indx_q, mv_indx_d;
  logic [15:0]       cmd_q, cmd_d;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic              tour_err_q, tour_err_d;
  logic              armed_q, armed_d;
  logic signed [2:0] dx_q, dx_d;

  logic signed [2:0] dec_dx, dec_dy;
  logic              dec_valid;

  knight_move_decode u_decode (
    .move  (move),
    .dx    (dec_dx),
    .dy    (dec_dy),
    .valid (dec_valid)
  );

  // armed_q marks that V_LEG has already sampled this index's move.
  always_comb begin
    state_d    = state_q;
    mv_indx_d  = mv_indx_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = cmd_rdy_q;
    armed_d    = armed_q;
    dx_d       = dx_q;
    tour_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_tour) begin
          state_d   = V_LEG;
          mv_indx_d = '0;
          armed_d   = 1'b0;
          cmd_rdy_d = 1'b0;
        end
      end
      V_LEG: begin
        if (!armed_q) begin
          if (!dec_valid) begin
            tour_err_d = 1'b1;
            state_d    = IDLE;
          end else begin
            cmd_d     = leg_cmd(OPC_MOVE, dec_dy, HDG_N, HDG_S);
            cmd_rdy_d = 1'b1;
            dx_d      = dec_dx;
            armed_d   = 1'b1;
          end
        end else if (clr_cmd_rdy) begin
          cmd_rdy_d = 1'b0;
          state_d   = V_WAIT;
        end
      end
      V_WAIT: begin
        if (send_resp) begin
          cmd_d     = leg_cmd(OPC_H, dx_q, HDG_E, HDG_W);
          cmd_rdy_d = 1'b1;
          state_d   = H_LEG;
        end
      end
      H_LEG: begin
        if (clr_cmd_rdy) begin
          cmd_rdy_d = 1'b0;
          state_d   = H_WAIT;
        end
      end
      H_WAIT: begin
        if (send_resp) begin
          if (mv_indx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            mv_indx_d = mv_indx_q + 5'd1;
            armed_d   = 1'b0;
            state_d   = V_LEG;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        cmd_rdy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mv_indx_q  <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      tour_err_q <= 1'b0;
      armed_q    <= 1'b0;
      dx_q       <= '0;
    end else begin
      state_q    <= state_d;
      mv_indx_q  <= mv_indx_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
      tour_err_q <= tour_err_d;
      armed_q    <= armed_d;
      dx_q       <= dx_d;
    end
  end

  // Idle mux is combinational so UART commands reach cmd_proc in the same cycle.
  assign cmd      = (state_q == IDLE) ? cmd_UART     : cmd_q;
  assign cmd_rdy  = (state_q == IDLE) ? cmd_rdy_UART : cmd_rdy_q;
  assign resp     = ((state_q == IDLE) ||
                     ((state_q == H_WAIT) && (mv_indx_q == LAST_IDX))) ? RESP_ACK : RESP_INT;
  assign mv_indx  = mv_indx_q;
  assign tour_err = tour_err_q;

endmodule

// File: tb/tb_tour_move_sched.sv
// Self-checking bench for tour_move_sched: randomized tours against a move-table reference model.
module tb_tour_move_sched;

  localparam int NUM_MOVES = 24;
`ifdef TOUR_FANFARE_EN
  localparam logic [3:0] EXP_OPC_H = 4'h5;
`else
  localparam logic [3:0] EXP_OPC_H = 4'h4;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;
  logic        tour_err;

  logic [7:0]  move_tbl [32];
  int          checks = 0;
  int          errors = 0;
  int          dx_of [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int          dy_of [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  always #5 clk = ~clk;

  assign move = move_tbl[mv_indx];

  tour_move_sched #(.NUM_MOVES(NUM_MOVES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .resp         (resp),
    .tour_err     (tour_err)
  );

  function automatic logic [15:0] leg_expect(input int idx, input bit horiz);
    int b, d, mag;
    logic [7:0] hdg;
    logic [3:0] opc;
    b = 0;
    for (int i = 0; i < 8; i++) if (move_tbl[idx][i]) b = i;
    d   = horiz ? dx_of[b] : dy_of[b];
    mag = (d < 0) ? -d : d;
    if (horiz) begin
      opc = EXP_OPC_H;
      hdg = (d > 0) ? 8'hBF : 8'h3F;
    end else begin
      opc = 4'h4;
      hdg = (d > 0) ? 8'h00 : 8'h7F;
    end
    return {opc, hdg, 4'(mag)};
  endfunction

  task automatic fill_random;
    for (int i = 0; i < 32; i++) move_tbl[i] = 8'h01 << $urandom_range(0, 7);
  endtask

  task automatic pulse_start;
    cmd_rdy_UART = 1'b0;
    @(posedge clk); #1;
    start_tour = 1'b1;
    @(posedge clk); #1;
    start_tour = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_tour = 0; cmd_UART = 16'h0; cmd_rdy_UART = 0;
    clr_cmd_rdy = 0; send_resp = 0;
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_cmd_rdy got %0b want 0", cmd_rdy); end
    checks++; if (mv_indx !== 5'd0) begin errors++; $display("FAIL reset_mv_indx got %0d want 0", mv_indx); end
    checks++; if (tour_err !== 1'b0) begin errors++; $display("FAIL reset_tour_err got %0b want 0", tour_err); end
    checks++; if (resp !== 8'hA5) begin errors++; $display("FAIL reset_resp got %h want a5", resp); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_passthru;
    logic [15:0] c;
    logic        r;
    cmd_UART = 16'h4004; cmd_rdy_UART = 1'b1;
    #1;
    checks++; if (cmd !== 16'h4004 || cmd_rdy !== 1'b1)
      begin errors++; $display("FAIL idle_4004 got cmd=%h rdy=%0b want cmd=4004 rdy=1", cmd, cmd_rdy); end
    for (int i = 0; i < 6; i++) begin
      c = 16'($urandom); r = 1'($urandom);
      cmd_UART = c; cmd_rdy_UART = r;
      #1;
      checks++; if (cmd !== c || cmd_rdy !== r)
        begin errors++; $display("FAIL idle_rand got cmd=%h rdy=%0b want cmd=%h rdy=%0b", cmd, cmd_rdy, c, r); end
      @(posedge clk); #1;
    end
    cmd_rdy_UART = 1'b0;
  endtask

  // err_idx < 0: legal full tour; otherwise move_tbl[err_idx] must be illegal.
  task automatic run_tour(input int err_idx, input string name);
    int n_legs, leg, budget, hold, gap, err_pulses;
    logic [15:0] exp_c;
    logic [7:0]  exp_r;
    n_legs = (err_idx < 0) ? 2 * NUM_MOVES : 2 * err_idx;
    leg    = 0;
    budget = 4000;
    pulse_start();
    while (leg < n_legs && budget > 0) begin
      while (cmd_rdy !== 1'b1 && budget > 0) begin
        cmd_UART = 16'($urandom); cmd_rdy_UART = 1'($urandom);
        @(posedge clk); #1;
        budget--;
      end
      if (budget == 0) break;
      exp_c = leg_expect(leg / 2, (leg % 2) == 1);
      checks++; if (cmd !== exp_c)
        begin errors++; $display("FAIL %s cmd leg %0d got %h want %h", name, leg, cmd, exp_c); end
      checks++; if (mv_indx !== 5'(leg / 2) || tour_err !== 1'b0)
        begin errors++; $display("FAIL %s idx leg %0d got mv_indx=%0d err=%0b want %0d 0", name, leg, mv_indx, tour_err, leg / 2); end
      checks++; if (resp !== 8'h5A)
        begin errors++; $display("FAIL %s leg_resp leg %0d got %h want 5a", name, leg, resp); end
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        start_tour = ($urandom_range(0, 3) == 0);
        cmd_UART = 16'($urandom); cmd_rdy_UART = 1'($urandom);
        @(posedge clk); #1;
        start_tour = 1'b0;
        checks++; if (cmd_rdy !== 1'b1 || cmd !== exp_c)
          begin errors++; $display("FAIL %s hold leg %0d got cmd=%h rdy=%0b want %h 1", name, leg, cmd, cmd_rdy, exp_c); end
      end
      clr_cmd_rdy = 1'b1; send_resp = 1'($urandom); cmd_rdy_UART = 1'b0;
      @(posedge clk); #1;
      clr_cmd_rdy = 1'b0; send_resp = 1'b0;
      checks++; if (cmd_rdy !== 1'b0)
        begin errors++; $display("FAIL %s drop leg %0d got rdy=%0b want 0", name, leg, cmd_rdy); end
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk); #1;
        checks++; if (cmd_rdy !== 1'b0)
          begin errors++; $display("FAIL %s wait leg %0d got rdy=%0b want 0", name, leg, cmd_rdy); end
      end
      exp_r = (leg == 2 * NUM_MOVES - 1) ? 8'hA5 : 8'h5A;
      checks++; if (resp !== exp_r)
        begin errors++; $display("FAIL %s wait_resp leg %0d got %h want %h", name, leg, resp, exp_r); end
      send_resp = 1'b1;
      @(posedge clk); #1;
      send_resp = 1'b0;
      leg++;
    end
    checks++; if (leg != n_legs)
      begin errors++; $display("FAIL %s leg_count got %0d want %0d", name, leg, n_legs); end
    if (err_idx < 0) begin
      checks++; if (resp !== 8'hA5 || mv_indx !== 5'(NUM_MOVES - 1))
        begin errors++; $display("FAIL %s end got resp=%h idx=%0d want a5 %0d", name, resp, mv_indx, NUM_MOVES - 1); end
      cmd_UART = 16'($urandom); cmd_rdy_UART = 1'b1;
      #1;
      checks++; if (cmd_rdy !== 1'b1 || cmd !== cmd_UART)
        begin errors++; $display("FAIL %s idle_return got cmd=%h rdy=%0b want %h 1", name, cmd, cmd_rdy, cmd_UART); end
      cmd_rdy_UART = 1'b0;
    end else begin
      err_pulses = 0;
      for (int c = 0; c < 6; c++) begin
        if (tour_err === 1'b1) err_pulses++;
        checks++; if (cmd_rdy !== 1'b0)
          begin errors++; $display("FAIL %s err_rdy cyc %0d got %0b want 0", name, c, cmd_rdy); end
        @(posedge clk); #1;
      end
      checks++; if (err_pulses != 1)
        begin errors++; $display("FAIL %s err_pulse got %0d cycles want 1", name, err_pulses); end
      checks++; if (resp !== 8'hA5 || mv_indx !== 5'(err_idx))
        begin errors++; $display("FAIL %s err_idle got resp=%h idx=%0d want a5 %0d", name, resp, mv_indx, err_idx); end
    end
  endtask

  task automatic test_reset_mid;
    int budget;
    fill_random();
    pulse_start();
    for (int l = 0; l < 4; l++) begin
      budget = 50;
      while (cmd_rdy !== 1'b1 && budget > 0) begin @(posedge clk); #1; budget--; end
      checks++; if (budget == 0)
        begin errors++; $display("FAIL rst_mid timeout leg %0d got rdy=%0b want 1", l, cmd_rdy); end
      clr_cmd_rdy = 1'b1;
      @(posedge clk); #1;
      clr_cmd_rdy = 1'b0;
      if (l < 3) begin
        @(posedge clk); #1;
        send_resp = 1'b1;
        @(posedge clk); #1;
        send_resp = 1'b0;
      end
    end
    checks++; if (resp !== 8'h5A || mv_indx !== 5'd1)
      begin errors++; $display("FAIL rst_mid pre got resp=%h idx=%0d want 5a 1", resp, mv_indx); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cmd_rdy !== 1'b0 || mv_indx !== 5'd0 || tour_err !== 1'b0)
      begin errors++; $display("FAIL rst_mid in_reset got rdy=%0b idx=%0d err=%0b want 0 0 0", cmd_rdy, mv_indx, tour_err); end
    @(negedge clk);
    rst_n = 1'b1;
    cmd_UART = 16'h4004; cmd_rdy_UART = 1'b1;
    #1;
    checks++; if (cmd_rdy !== 1'b1 || cmd !== 16'h4004)
      begin errors++; $display("FAIL rst_mid passthru got cmd=%h rdy=%0b want 4004 1", cmd, cmd_rdy); end
    cmd_rdy_UART = 1'b0;
    send_resp = 1'b1;
    @(posedge clk); #1;
    send_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cmd_rdy !== 1'b0 || mv_indx !== 5'd0 || resp !== 8'hA5)
      begin errors++; $display("FAIL rst_mid after got rdy=%0b idx=%0d resp=%h want 0 0 a5", cmd_rdy, mv_indx, resp); end
  endtask

  initial begin
    test_reset();
    test_idle_passthru();
    for (int i = 0; i < 32; i++) move_tbl[i] = 8'h01;
    run_tour(-1, "tour_01");
    for (int i = 0; i < 32; i++) move_tbl[i] = 8'h08;
    run_tour(-1, "tour_08");
    for (int t = 0; t < 3; t++) begin
      fill_random();
      run_tour(-1, "tour_rand");
    end
    fill_random();
    move_tbl[5] = 8'h03;
    run_tour(5, "tour_err03");
    fill_random();
    move_tbl[2] = 8'h00;
    run_tour(2, "tour_err00");
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tour_move_sched.md
TOUR_MOVE_SCHED -- requirements
Module: tour_move_sched

Interface
REQ-001 Parameter: NUM_MOVES, default 24, number of knight moves in one tour (indices 0..NUM_MOVES-1).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start_tour  input  1  one-cycle pulse; tour solution is ready, begin sequencing.
REQ-005 move  input  8  one-hot knight move for current mv_indx, from tour solver.
REQ-006 mv_indx  output  5  index of the move being executed.
REQ-007 cmd_UART  input  16  command from UART wrapper.
REQ-008 cmd_rdy_UART  input  1  UART command valid.
REQ-009 clr_cmd_rdy  input  1  cmd_proc has consumed cmd.
REQ-010 send_resp  input  1  cmd_proc finished a move.
REQ-011 cmd  output  16  command muxed to cmd_proc.
REQ-012 cmd_rdy  output  1  cmd valid to cmd_proc.
REQ-013 resp  output  8  response byte forwarded to UART.
REQ-014 tour_err  output  1  one-cycle pulse on illegal move encoding.

Function
REQ-015 Command format: [15:12] opcode (4 = move, 5 = move with fanfare), [11:4] heading (8'h00 N, 8'h3F W, 8'h7F S, 8'hBF E), [3:0] squares.
REQ-016 States: IDLE, V_LEG, V_WAIT, H_LEG, H_WAIT.
REQ-017 IDLE: cmd = cmd_UART, cmd_rdy = cmd_rdy_UART, resp = 8'hA5.
REQ-018 IDLE + start_tour -> V_LEG, mv_indx = 0 on the next cycle.
REQ-019 Move decode (dx,dy): bit0 (+1,+2), bit1 (-1,+2), bit2 (-2,+1), bit3 (-2,-1), bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1).
REQ-020 V_LEG: cmd = {4'h4, dy>0 ? 8'h00 : 8'h7F, |dy|}; cmd_rdy = 1 until clr_cmd_rdy seen, then -> V_WAIT.
REQ-021 V_WAIT: cmd_rdy = 0; send_resp -> H_LEG.
REQ-022 H_LEG: cmd = {opcode_h, dx>0 ? 8'hBF : 8'h3F, |dx|}; cmd_rdy = 1 until clr_cmd_rdy, then -> H_WAIT.
REQ-023 H_WAIT: send_resp with mv_indx < NUM_MOVES-1 -> mv_indx+1, V_LEG; with mv_indx = NUM_MOVES-1 -> IDLE.
REQ-024 Outside IDLE, cmd_rdy_UART and cmd_UART are ignored; no UART command is queued.
REQ-025 resp = 8'h5A outside IDLE, except 8'hA5 in H_WAIT when mv_indx = NUM_MOVES-1.
REQ-026 start_tour outside IDLE is ignored.
REQ-027 Zero or non-one-hot move sampled on V_LEG entry -> tour_err pulses for 1 cycle, state -> IDLE, no cmd_rdy issued.
REQ-028 clr_cmd_rdy and send_resp arriving in the same cycle: clr_cmd_rdy takes effect; send_resp is ignored unless the state is V_WAIT or H_WAIT.
REQ-029 cmd and cmd_rdy are registered; cmd is stable for the entire time cmd_rdy is high.

Reset
REQ-030 rst_n low -> IDLE, mv_indx = 0, cmd_rdy = 0, tour_err = 0, regardless of any tour in progress.
REQ-031 No tour state survives reset; a new start_tour is required.

Configuration
REQ-032 TOUR_FANFARE_EN defined: opcode_h = 4'h5 (fanfare on every horizontal leg). Undefined: opcode_h = 4'h4.
REQ-033 The V_LEG opcode is always 4'h4, whether or not TOUR_FANFARE_EN is defined.

Structure
REQ-034 The shared package holds: opcode constants, heading constants, the state enum, and the ACK (8'hA5) / intermediate (8'h5A) constants.
REQ-035 One sub-module, knight_move_decode: combinational move[7:0] -> signed dx, dy plus a valid flag.

Verification
REQ-036 IDLE, cmd_UART = 16'h4004, cmd_rdy_UART = 1 -> cmd = 16'h4004, cmd_rdy = 1 in the same cycle.
REQ-037 start_tour, move = 8'h01 -> cmd 16'h4002, then after clr_cmd_rdy and send_resp -> cmd 16'h4BF1 (16'h5BF1 with TOUR_FANFARE_EN), resp = 8'h5A.
REQ-038 move = 8'h08 -> cmd 16'h47F1 then 16'h43F2.
REQ-039 Full 24-move tour with an auto-responding cmd_proc model -> 48 commands issued, resp = 8'hA5 on the last leg, return to IDLE, mv_indx = 23.
REQ-040 move = 8'h03 at index 5 -> tour_err pulses, IDLE, cmd_rdy stays 0.
REQ-041 rst_n low in H_WAIT -> IDLE, mv_indx = 0, cmd_rdy = 0; cmd_rdy_UART is passed through after reset.
